// File: rtl/imem_loader_if.sv
`default_nettype none
//==========================================================================
// Module   : imem_loader_if
// Purpose  : Byte-stream input and instruction-memory write bus of the loader.
// Revision : 1.0
//==========================================================================
interface imem_loader_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  // master: stream source that also observes the memory writes
  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

  // slave: the loader itself
  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
//==========================================================================
// Module   : imem_loader
// Purpose  : Loads a length-prefixed big-endian byte image into instruction
//            memory and holds the CPU in reset until the load succeeds.
// Option   : IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
// Revision : 1.0
//==========================================================================
module imem_loader #(
  parameter int ADDR_W      = 10,
  parameter int DEPTH_WORDS = 256
) (
  input  logic         clk,
  input  logic         Reset,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         cpu_hold,
  output logic         load_done,
  output logic         load_err,
  output logic [15:0]  words_loaded
);

  localparam logic [15:0] c_depth = 16'(DEPTH_WORDS);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR    = 3'd5
`ifdef IMEM_LOADER_CHECKSUM_EN
    , ST_CSUM = 3'd6
`endif
  } state_t;

  state_t            r_state,      w_state_nx;
  logic              r_in_ready,   w_in_ready_nx;
  logic              r_mem_we,     w_mem_we_nx;
  logic [ADDR_W-1:0] r_mem_addr,   w_mem_addr_nx;
  logic [31:0]       r_mem_wdata,  w_mem_wdata_nx;
  logic              r_cpu_hold,   w_cpu_hold_nx;
  logic              r_load_done,  w_load_done_nx;
  logic              r_load_err,   w_load_err_nx;
  logic [15:0]       r_words,      w_words_nx;
  logic [15:0]       r_len,        w_len_nx;
  logic [23:0]       r_shift,      w_shift_nx;
  logic [1:0]        r_byte_cnt,   w_byte_cnt_nx;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        r_csum,       w_csum_nx;
`endif

  logic              w_xfer;
  logic [15:0]       w_len_full;
  logic [15:0]       w_words_inc;

  assign w_xfer      = bus.in_valid & r_in_ready;
  assign w_len_full  = {r_len[15:8], bus.in_data};
  assign w_words_inc = r_words + 16'd1;

  always_comb begin
    w_state_nx     = r_state;
    w_in_ready_nx  = r_in_ready;
    w_mem_we_nx    = 1'b0;
    w_mem_addr_nx  = r_mem_addr;
    w_mem_wdata_nx = r_mem_wdata;
    w_cpu_hold_nx  = r_cpu_hold;
    w_load_done_nx = r_load_done;
    w_load_err_nx  = r_load_err;
    w_words_nx     = r_words;
    w_len_nx       = r_len;
    w_shift_nx     = r_shift;
    w_byte_cnt_nx  = r_byte_cnt;
`ifdef IMEM_LOADER_CHECKSUM_EN
    w_csum_nx      = r_csum;
`endif

    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          w_state_nx     = ST_LEN_HI;
          w_in_ready_nx  = 1'b1;
          w_load_done_nx = 1'b0;
          w_load_err_nx  = 1'b0;
          w_words_nx     = 16'd0;
          w_mem_addr_nx  = '0;
          w_cpu_hold_nx  = 1'b1;
          w_byte_cnt_nx  = 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          w_csum_nx      = 8'h00;
`endif
        end
      end

      ST_LEN_HI: begin
        if (w_xfer) begin
          w_len_nx   = {bus.in_data, r_len[7:0]};
          w_state_nx = ST_LEN_LO;
        end
      end

      ST_LEN_LO: begin
        if (w_xfer) begin
          w_len_nx = w_len_full;
          if (w_len_full == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            // the checksum byte is still sent for an empty image
            w_state_nx     = ST_CSUM;
`else
            w_state_nx     = ST_DONE;
            w_in_ready_nx  = 1'b0;
            w_load_done_nx = 1'b1;
            w_cpu_hold_nx  = 1'b0;
`endif
          end else if (w_len_full > c_depth) begin
            w_state_nx    = ST_ERR;
            w_in_ready_nx = 1'b0;
            w_load_err_nx = 1'b1;
          end else begin
            w_state_nx = ST_DATA;
          end
        end
      end

      ST_DATA: begin
`ifndef IMEM_LOADER_CHECKSUM_EN
        // final word is being written this cycle; release the CPU next
        if (r_words == r_len) begin
          w_state_nx     = ST_DONE;
          w_load_done_nx = 1'b1;
          w_cpu_hold_nx  = 1'b0;
        end else
`endif
        if (w_xfer) begin
          w_byte_cnt_nx = r_byte_cnt + 2'd1;
          w_shift_nx    = {r_shift[15:0], bus.in_data};
`ifdef IMEM_LOADER_CHECKSUM_EN
          w_csum_nx     = r_csum ^ bus.in_data;
`endif
          if (r_byte_cnt == 2'd3) begin
            w_mem_we_nx    = 1'b1;
            w_mem_wdata_nx = {r_shift, bus.in_data};
            w_mem_addr_nx  = {r_words[ADDR_W-3:0], 2'b00};
            w_words_nx     = w_words_inc;
            if (w_words_inc == r_len) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              w_state_nx    = ST_CSUM;
`else
              w_in_ready_nx = 1'b0;
`endif
            end
          end
        end
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (w_xfer) begin
          w_in_ready_nx = 1'b0;
          if (bus.in_data == r_csum) begin
            w_state_nx     = ST_DONE;
            w_load_done_nx = 1'b1;
            w_cpu_hold_nx  = 1'b0;
          end else begin
            w_state_nx    = ST_ERR;
            w_load_err_nx = 1'b1;
          end
        end
      end
`endif

      default: begin
        w_state_nx    = ST_IDLE;
        w_in_ready_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'd0;
      r_cpu_hold  <= 1'b1;
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
      r_words     <= 16'd0;
      r_len       <= 16'd0;
      r_shift     <= 24'd0;
      r_byte_cnt  <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum      <= 8'h00;
`endif
    end else begin
      r_state     <= w_state_nx;
      r_in_ready  <= w_in_ready_nx;
      r_mem_we    <= w_mem_we_nx;
      r_mem_addr  <= w_mem_addr_nx;
      r_mem_wdata <= w_mem_wdata_nx;
      r_cpu_hold  <= w_cpu_hold_nx;
      r_load_done <= w_load_done_nx;
      r_load_err  <= w_load_err_nx;
      r_words     <= w_words_nx;
      r_len       <= w_len_nx;
      r_shift     <= w_shift_nx;
      r_byte_cnt  <= w_byte_cnt_nx;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum      <= w_csum_nx;
`endif
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign cpu_hold      = r_cpu_hold;
  assign load_done     = r_load_done;
  assign load_err      = r_load_err;
  assign words_loaded  = r_words;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
//==========================================================================
// Module   : tb_imem_loader
// Purpose  : Self-checking bench for imem_loader (honours IMEM_LOADER_CHECKSUM_EN).
// Revision : 1.0
//==========================================================================
module tb_imem_loader;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 256;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit c_csum_en = 1'b1;
`else
  localparam bit c_csum_en = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        Reset = 1'b0;
  logic        start = 1'b0;
  logic        cpu_hold, load_done, load_err;
  logic [15:0] words_loaded;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH_WORDS(DEPTH)) dut (
    .clk          (clk),
    .Reset        (Reset),
    .start        (start),
    .bus          (bus.slave),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model state for the load in flight
  logic [7:0]        stim[$];
  logic [31:0]       exp_q[$];
  logic [ADDR_W-1:0] exp_a[$];
  logic [31:0]       exp_mem [0:DEPTH-1];
  logic [31:0]       instmem [0:DEPTH-1];
  int                exp_words;
  bit                exp_err;
  logic [7:0]        last_cs;
  int                writes_seen;
  logic [ADDR_W-1:0] first_addr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // expected writes and status from the image rules; appends the checksum byte when enabled
  task automatic prep_model(input bit bad_csum);
    int n;
    bit len_err;
    logic [7:0] cs;
    n       = int'({stim[0], stim[1]});
    len_err = (n > DEPTH);
    exp_q.delete();
    exp_a.delete();
    cs = 8'h00;
    if (!len_err) begin
      for (int k = 0; k < n; k++) begin
        exp_mem[k] = {stim[2+4*k], stim[3+4*k], stim[4+4*k], stim[5+4*k]};
        exp_q.push_back(exp_mem[k]);
        exp_a.push_back(ADDR_W'(k * 4));
      end
      for (int i = 2; i < 2 + 4 * n; i++) cs = cs ^ stim[i];
      if (c_csum_en) stim.push_back(bad_csum ? (cs ^ 8'h01) : cs);
    end
    last_cs   = cs;
    exp_err   = len_err | (bad_csum & c_csum_en);
    exp_words = len_err ? 0 : n;
    writes_seen = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // called at a negedge; returns at the negedge after the byte was taken
  task automatic send_byte(input logic [7:0] b);
    int n;
    int gap;
    gap = $urandom_range(0, 2);
    if (gap != 0) begin
      bus.in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
  endtask

  task automatic send_bytes(input int count);
    for (int i = 0; i < count; i++) send_byte(stim[i]);
    bus.in_valid = 1'b0;
  endtask

  task automatic check_end();
    repeat (4) @(negedge clk);
    chk("load_done",    {31'd0, load_done}, exp_err ? 32'd0 : 32'd1);
    chk("load_err",     {31'd0, load_err},  exp_err ? 32'd1 : 32'd0);
    chk("cpu_hold",     {31'd0, cpu_hold},  exp_err ? 32'd1 : 32'd0);
    chk("words_loaded", {16'd0, words_loaded}, exp_words);
    chk("writes_seen",  writes_seen, exp_words);
    chk("pending",      exp_q.size(), 32'd0);
    chk("in_ready_end", {31'd0, bus.in_ready}, 32'd0);
    for (int k = 0; k < exp_words; k++) chk("instmem_read", instmem[k], exp_mem[k]);
  endtask

  task automatic run_load(input bit bad_csum);
    prep_model(bad_csum);
    pulse_start();
    send_bytes(stim.size());
    check_end();
  endtask

  task automatic check_reset_values();
    chk("rst_cpu_hold",  {31'd0, cpu_hold},      32'd1);
    chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
    chk("rst_load_done", {31'd0, load_done},     32'd0);
    chk("rst_load_err",  {31'd0, load_err},      32'd0);
    chk("rst_mem_we",    {31'd0, bus.mem_we},    32'd0);
    chk("rst_mem_addr",  {22'd0, bus.mem_addr},  32'd0);
    chk("rst_mem_wdata", bus.mem_wdata,          32'd0);
    chk("rst_words",     {16'd0, words_loaded},  32'd0);
  endtask

  // write monitor: every write must be the next one the model predicts
  always @(negedge clk) begin
    if (Reset) begin
      chk("hold_vs_done", {31'd0, cpu_hold}, load_done ? 32'd0 : 32'd1);
      if (bus.mem_we) begin
        chk("write_expected", (exp_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
        if (exp_q.size() != 0) begin
          chk("mem_addr",  {22'd0, bus.mem_addr}, {22'd0, exp_a.pop_front()});
          chk("mem_wdata", bus.mem_wdata, exp_q.pop_front());
        end
        writes_seen++;
        if (writes_seen == 1) first_addr = bus.mem_addr;
        chk("words_at_write", {16'd0, words_loaded}, writes_seen);
        instmem[bus.mem_addr[ADDR_W-1:2]] = bus.mem_wdata;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    for (int k = 0; k < DEPTH; k++) instmem[k] = 32'hDEAD_BEEF;

    // reset held for two clocks
    repeat (2) @(negedge clk);
    Reset = 1'b1;
    @(negedge clk);
    check_reset_values();

    // two-word image
    stim = '{8'h00, 8'h02, 8'h00, 8'h00, 8'h48, 8'h20, 8'h08, 8'h00, 8'h00, 8'h0C};
    run_load(1'b0);
    chk("lit_word0", instmem[0], 32'h0000_4820);
    chk("lit_word1", instmem[1], 32'h0800_000C);
    chk("lit_words", {16'd0, words_loaded}, 32'd2);
    chk("lit_csum",  {24'd0, last_cs}, 32'h6C);

    // empty image
    stim = '{8'h00, 8'h00};
    run_load(1'b0);
    chk("lit_empty_words", {16'd0, words_loaded}, 32'd0);

    // over-length image
    stim = '{8'h01, 8'h01};
    run_load(1'b0);
    chk("lit_overlen_err", {31'd0, load_err}, 32'd1);

    // three words of varied data
    stim = '{8'h00, 8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78,
             8'hFF, 8'h00, 8'hA5, 8'h5A};
    run_load(1'b0);
    chk("lit_w2", instmem[2], 32'hFF00_A55A);

    // largest accepted image
    stim = '{8'h01, 8'h00};
    for (int i = 0; i < 4 * DEPTH; i++) stim.push_back(8'($urandom_range(0, 255)));
    run_load(1'b0);

    // reset in the middle of word 1
    stim = '{8'h00, 8'h02, 8'h00, 8'h00, 8'h48, 8'h20, 8'h08, 8'h00, 8'h00, 8'h0C};
    prep_model(1'b0);
    pulse_start();
    send_bytes(8);
    Reset = 1'b0;
    #1;
    check_reset_values();
    exp_q.delete();
    exp_a.delete();
    repeat (2) @(negedge clk);
    Reset = 1'b1;
    @(negedge clk);
    stim = '{8'h00, 8'h02, 8'h00, 8'h00, 8'h48, 8'h20, 8'h08, 8'h00, 8'h00, 8'h0C};
    first_addr = '1;
    run_load(1'b0);
    chk("lit_first_addr", {22'd0, first_addr}, 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    stim = '{8'h00, 8'h02, 8'h00, 8'h00, 8'h48, 8'h20, 8'h08, 8'h00, 8'h00, 8'h0C};
    run_load(1'b0);
    chk("lit_csum_ok", {31'd0, load_done}, 32'd1);
    stim = '{8'h00, 8'h02, 8'h00, 8'h00, 8'h48, 8'h20, 8'h08, 8'h00, 8'h00, 8'h0C};
    run_load(1'b1);
    chk("lit_csum_bad", {31'd0, load_err}, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
